bf16_dot_sequencer: RTL and testbench

- Controller that computes an N-element BF16 dot product on one shared bfloat_mac2 lane, instead of using N parallel MAC lanes.
- Accepts two operand vectors over a valid/ready handshake.
- Issues one element pair per slot to the MAC and drives the MAC's cntl input: 0 = load a*b, 1 = accumulate out+a*b.
- Returns the scalar result over a valid/ready handshake.

---
 rtl/bf16_mac_pkg.sv | 17 +
 rtl/bf16_dot_unit.sv | 54 +++++
 rtl/bfloat_mac2.sv | 84 ++++++++
 rtl/bf16_dot_sequencer.sv | 121 ++++++++++++
 tb/tb_bf16_dot_sequencer.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bf16_mac_pkg.sv
// Shared types and constants for the BF16 dot-product sequencer and its MAC lane.
package bf16_mac_pkg;

    typedef logic [15:0] bf16_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPT,
        DONE
    } seq_state_t;

    localparam bf16_t BF16_ZERO = 16'h0000;
    localparam logic  CNTL_LOAD = 1'b0;
    localparam logic  CNTL_ACC  = 1'b1;

endpackage

// File: rtl/bf16_dot_unit.sv
// Integration wrapper: one dot-product sequencer driving one shared BF16 MAC lane.
module bf16_dot_unit
    import bf16_mac_pkg::*;
#(
    parameter int N       = 4,
    parameter int MAC_LAT = 1
) (
    input  logic            clk1,
    input  logic            rst1,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [16*N-1:0] a_vec,
    input  logic [16*N-1:0] b_vec,
    output logic            out_valid,
    input  logic            out_ready,
    output bf16_t           out_data,
    output logic            busy
);

    bf16_t mac_a, mac_b, mac_out;
    logic  mac_cntl;

    bf16_dot_sequencer #(
        .N       (N),
        .MAC_LAT (MAC_LAT)
    ) u_seq (
        .clk1      (clk1),
        .rst1      (rst1),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_vec     (a_vec),
        .b_vec     (b_vec),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_cntl  (mac_cntl),
        .mac_out   (mac_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    bfloat_mac2 #(
        .LAT (MAC_LAT)
    ) u_mac (
        .clk1   (clk1),
        .rst1   (rst1),
        .a_i    (mac_a),
        .b_i    (mac_b),
        .cntl_i (mac_cntl),
        .out_o  (mac_out)
    );

endmodule

// File: rtl/bfloat_mac2.sv
// BF16 multiply-accumulate lane: out = a*b (load) or out + a*b (accumulate), visible LAT cycles later.
// Truncating rounding; subnormals flush to zero and overflow saturates to infinity.
module bfloat_mac2
    import bf16_mac_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic  clk1,
    input  logic  rst1,
    input  bf16_t a_i,
    input  bf16_t b_i,
    input  logic  cntl_i,
    output bf16_t out_o
);

    logic              p_s, c_s, x_s, y_s;
    logic              p_zero, c_zero, x_big;
    logic [15:0]       prod;
    logic signed [9:0] p_e, c_e, x_e, y_e, d_e, res_e;
    logic [15:0]       p_m, c_m, x_m, y_m, y_sh;
    logic [16:0]       sum, norm;
    logic [4:0]        hb;
    bf16_t             res;
    bf16_t             pipe_q [LAT];

    always_comb begin
        prod = {1'b1, a_i[6:0]} * {1'b1, b_i[6:0]};
        p_s  = a_i[15] ^ b_i[15];
        // Mantissas are kept with the hidden bit at position 15.
        if (prod[15]) begin
            p_m = prod;
            p_e = $signed({2'b00, a_i[14:7]}) + $signed({2'b00, b_i[14:7]}) - 10'sd126;
        end else begin
            p_m = {prod[14:0], 1'b0};
            p_e = $signed({2'b00, a_i[14:7]}) + $signed({2'b00, b_i[14:7]}) - 10'sd127;
        end
        p_zero = (a_i[14:7] == 8'd0) || (b_i[14:7] == 8'd0) || (p_e <= 10'sd0);
        if (p_zero) begin
            p_m = 16'd0;
            p_e = 10'sd0;
        end

        c_s    = out_o[15];
        c_zero = (cntl_i == CNTL_LOAD) || (out_o[14:7] == 8'd0);
        c_m    = c_zero ? 16'd0 : {1'b1, out_o[6:0], 8'd0};
        c_e    = c_zero ? 10'sd0 : $signed({2'b00, out_o[14:7]});

        x_big = (p_e > c_e) || ((p_e == c_e) && (p_m >= c_m));
        if (x_big) begin
            x_s = p_s; x_e = p_e; x_m = p_m;
            y_s = c_s; y_e = c_e; y_m = c_m;
        end else begin
            x_s = c_s; x_e = c_e; x_m = c_m;
            y_s = p_s; y_e = p_e; y_m = p_m;
        end

        d_e  = x_e - y_e;
        y_sh = (d_e > 10'sd16) ? 16'd0 : (y_m >> d_e[4:0]);
        sum  = (x_s == y_s) ? ({1'b0, x_m} + {1'b0, y_sh}) : ({1'b0, x_m} - {1'b0, y_sh});

        hb = 5'd0;
        for (int i = 0; i < 17; i++) begin
            if (sum[i]) hb = 5'(i);
        end
        norm  = sum << (5'd16 - hb);
        res_e = x_e + $signed({5'b00000, hb}) - 10'sd15;

        if ((sum == 17'd0) || (res_e <= 10'sd0)) res = BF16_ZERO;
        else if (res_e >= 10'sd255)              res = {x_s, 8'hFF, 7'h00};
        else                                     res = {x_s, res_e[7:0], 7'(norm >> 9)};
    end

    always_ff @(posedge clk1) begin
        if (rst1) begin
            for (int i = 0; i < LAT; i++) pipe_q[i] <= BF16_ZERO;
        end else begin
            pipe_q[0] <= res;
            for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign out_o = pipe_q[LAT-1];

endmodule

// File: rtl/bf16_dot_sequencer.sv
// Streams N BF16 element pairs through one shared MAC lane, one slot of MAC_LAT cycles per element,
// and returns the captured dot product over a valid/ready handshake.
module bf16_dot_sequencer
    import bf16_mac_pkg::*;
#(
    parameter int N       = 4,
    parameter int MAC_LAT = 1
) (
    input  logic            clk1,
    input  logic            rst1,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [16*N-1:0] a_vec,
    input  logic [16*N-1:0] b_vec,
    output bf16_t           mac_a,
    output bf16_t           mac_b,
    output logic            mac_cntl,
    input  bf16_t           mac_out,
    output logic            out_valid,
    input  logic            out_ready,
    output bf16_t           out_data,
    output logic            busy
);

    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int SLOT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(MAC_LAT - 1);

    seq_state_t        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [16*N-1:0]   a_q, b_q;
    bf16_t             out_data_q;
    logic              load_vec, capture;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        slot_d    = slot_q;
        load_vec  = 1'b0;
        capture   = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        mac_a     = BF16_ZERO;
        mac_b     = BF16_ZERO;
        mac_cntl  = CNTL_ACC;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    load_vec = 1'b1;
                    idx_d    = '0;
                    slot_d   = '0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                // Only the first cycle of a slot carries operands; the rest are 0*0 bubbles.
                if (slot_q == '0) begin
                    mac_a    = a_q[16*idx_q +: 16];
                    mac_b    = b_q[16*idx_q +: 16];
                    mac_cntl = (idx_q != '0) ? CNTL_ACC : CNTL_LOAD;
                end
                if (slot_q == SLOT_LAST) begin
                    slot_d = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = CAPT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end
            CAPT: begin
                capture = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A load of 0*0 while in reset leaves the MAC cleared.
        if (rst1) begin
            mac_a    = BF16_ZERO;
            mac_b    = BF16_ZERO;
            mac_cntl = CNTL_LOAD;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst1) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            slot_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            out_data_q <= BF16_ZERO;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            slot_q  <= slot_d;
            if (load_vec) begin
                a_q <= a_vec;
                b_q <= b_vec;
            end
            if (capture) out_data_q <= mac_out;
        end
    end

    assign out_data = out_data_q;

endmodule

// File: tb/tb_bf16_dot_sequencer.sv
// Directed bench: three sequencer+MAC pairs (N=4/L=1, N=2/L=3, N=1/L=1) with hand-computed results.
module tb_bf16_dot_sequencer;

    logic clk = 1'b0;
    logic rst1 = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Instance 0: N=4, MAC_LAT=1
    logic        iv0 = 1'b0, or0 = 1'b0;
    logic        ir0, ov0, busy0, mc0;
    logic [63:0] av0 = '0, bv0 = '0;
    logic [15:0] ma0, mb0, mo0, od0;
    // Instance 1: N=2, MAC_LAT=3
    logic        iv1 = 1'b0, or1 = 1'b0;
    logic        ir1, ov1, busy1, mc1;
    logic [31:0] av1 = '0, bv1 = '0;
    logic [15:0] ma1, mb1, mo1, od1;
    // Instance 2: N=1, MAC_LAT=1
    logic        iv2 = 1'b0, or2 = 1'b0;
    logic        ir2, ov2, busy2, mc2;
    logic [15:0] av2 = '0, bv2 = '0;
    logic [15:0] ma2, mb2, mo2, od2;

    logic [63:0] v1a = {16'h4080, 16'h4040, 16'h4000, 16'h3F80};
    logic [63:0] v1b = {4{16'h3F80}};
    logic [63:0] v2a = {4{16'h4000}};
    logic [63:0] v2b = {4{16'h3F00}};

    bf16_dot_sequencer #(.N(4), .MAC_LAT(1)) dut0 (
        .clk1(clk), .rst1(rst1), .in_valid(iv0), .in_ready(ir0), .a_vec(av0), .b_vec(bv0),
        .mac_a(ma0), .mac_b(mb0), .mac_cntl(mc0), .mac_out(mo0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0), .busy(busy0));
    bfloat_mac2 #(.LAT(1)) mac0 (
        .clk1(clk), .rst1(rst1), .a_i(ma0), .b_i(mb0), .cntl_i(mc0), .out_o(mo0));

    bf16_dot_sequencer #(.N(2), .MAC_LAT(3)) dut1 (
        .clk1(clk), .rst1(rst1), .in_valid(iv1), .in_ready(ir1), .a_vec(av1), .b_vec(bv1),
        .mac_a(ma1), .mac_b(mb1), .mac_cntl(mc1), .mac_out(mo1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .busy(busy1));
    bfloat_mac2 #(.LAT(3)) mac1 (
        .clk1(clk), .rst1(rst1), .a_i(ma1), .b_i(mb1), .cntl_i(mc1), .out_o(mo1));

    bf16_dot_sequencer #(.N(1), .MAC_LAT(1)) dut2 (
        .clk1(clk), .rst1(rst1), .in_valid(iv2), .in_ready(ir2), .a_vec(av2), .b_vec(bv2),
        .mac_a(ma2), .mac_b(mb2), .mac_cntl(mc2), .mac_out(mo2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2), .busy(busy2));
    bfloat_mac2 #(.LAT(1)) mac2 (
        .clk1(clk), .rst1(rst1), .a_i(ma2), .b_i(mb2), .cntl_i(mc2), .out_o(mo2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles from the accept edge (cycle after accept = 1) until out_valid; -1 on timeout.
    task automatic wait_u0(output int cyc, output logic rdy_seen);
        cyc = 1;
        rdy_seen = 1'b0;
        while (ov0 !== 1'b1 && cyc < 40) begin
            rdy_seen = rdy_seen | ir0;
            step();
            cyc++;
        end
        if (ov0 !== 1'b1) cyc = -1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (mc0 !== 1'b0) begin errors++; $display("FAIL reset_cntl: got %b expected 0", mc0); end
        step(); step();
        checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", ir0); end
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", ov0); end
        checks++; if (od0 !== 16'h0000) begin errors++; $display("FAIL reset_out_data: got %h expected 0000", od0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy0); end
        checks++; if (ma0 !== 16'h0000) begin errors++; $display("FAIL reset_mac_a: got %h expected 0000", ma0); end
        rst1 = 1'b0;
        step();
        checks++; if (mc0 !== 1'b1) begin errors++; $display("FAIL idle_cntl: got %b expected 1", mc0); end
        checks++; if (ma0 !== 16'h0000) begin errors++; $display("FAIL idle_mac_a: got %h expected 0000", ma0); end
        $display("test_reset done");
    endtask

    task automatic test_dot_basic();
        av0 = v1a; bv0 = v1b; iv0 = 1'b1;
        step();
        iv0 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (mc0 !== 1'(k != 0)) begin errors++; $display("FAIL basic_cntl[%0d]: got %b expected %b", k, mc0, k != 0); end
            checks++; if (ma0 !== v1a[16*k +: 16]) begin errors++; $display("FAIL basic_mac_a[%0d]: got %h expected %h", k, ma0, v1a[16*k +: 16]); end
            checks++; if (mb0 !== 16'h3F80) begin errors++; $display("FAIL basic_mac_b[%0d]: got %h expected 3f80", k, mb0); end
            step();
        end
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL basic_capt_valid: got %b expected 0", ov0); end
        step();
        checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL basic_valid_at_6: got %b expected 1", ov0); end
        checks++; if (od0 !== 16'h4120) begin errors++; $display("FAIL basic_data: got %h expected 4120", od0); end
        or0 = 1'b1;
        step();
        or0 = 1'b0;
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b expected 0", ov0); end
        checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL basic_back_idle: got %b expected 1", ir0); end
        $display("test_dot_basic done: out_data=%h", od0);
    endtask

    task automatic test_back_to_back();
        int   cyc;
        logic rdy;
        av0 = v1a; bv0 = v1b; iv0 = 1'b1; or0 = 1'b1;
        step();
        av0 = v2a; bv0 = v2b;
        wait_u0(cyc, rdy);
        checks++; if (cyc != 6) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 6", cyc); end
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL b2b_in_ready_busy: got %b expected 0", rdy); end
        checks++; if (od0 !== 16'h4120) begin errors++; $display("FAIL b2b_first_data: got %h expected 4120", od0); end
        step();
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL b2b_consumed: got %b expected 0", ov0); end
        checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL b2b_idle_ready: got %b expected 1", ir0); end
        step();
        iv0 = 1'b0;
        wait_u0(cyc, rdy);
        checks++; if (cyc != 6) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 6", cyc); end
        checks++; if (od0 !== 16'h4080) begin errors++; $display("FAIL b2b_second_data: got %h expected 4080", od0); end
        step();
        or0 = 1'b0;
        checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL b2b_final_idle: got %b expected 1", ir0); end
        $display("test_back_to_back done: out_data=%h", od0);
    endtask

    task automatic test_backpressure();
        int   cyc;
        logic rdy;
        av0 = v1a; bv0 = v1b; iv0 = 1'b1; or0 = 1'b0;
        step();
        iv0 = 1'b0;
        wait_u0(cyc, rdy);
        checks++; if (cyc != 6) begin errors++; $display("FAIL bp_latency: got %0d expected 6", cyc); end
        for (int k = 0; k < 10; k++) begin
            checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", k, ov0); end
            checks++; if (od0 !== 16'h4120) begin errors++; $display("FAIL bp_data[%0d]: got %h expected 4120", k, od0); end
            checks++; if (ir0 !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", k, ir0); end
            checks++; if (mc0 !== 1'b1) begin errors++; $display("FAIL bp_cntl[%0d]: got %b expected 1", k, mc0); end
            checks++; if ({ma0, mb0} !== 32'h0) begin errors++; $display("FAIL bp_operands[%0d]: got %h expected 0", k, {ma0, mb0}); end
            checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL bp_busy[%0d]: got %b expected 1", k, busy0); end
            step();
        end
        or0 = 1'b1;
        step();
        or0 = 1'b0;
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", ov0); end
        checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL bp_release_idle: got %b expected 1", ir0); end
        step(); step();
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL bp_single_transfer: got %b expected 0", ov0); end
        $display("test_backpressure done");
    endtask

    task automatic test_mac_lat3();
        logic [15:0] ea [6];
        logic [5:0]  ec;
        ea = '{16'h4000, 16'h0000, 16'h0000, 16'h4040, 16'h0000, 16'h0000};
        ec = 6'b111110;
        checks++; if (ir1 !== 1'b1) begin errors++; $display("FAIL l3_idle_ready: got %b expected 1", ir1); end
        av1 = {16'h4040, 16'h4000}; bv1 = {16'h4000, 16'h4000}; iv1 = 1'b1;
        step();
        iv1 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            checks++; if (mc1 !== ec[k]) begin errors++; $display("FAIL l3_cntl[%0d]: got %b expected %b", k, mc1, ec[k]); end
            checks++; if (ma1 !== ea[k]) begin errors++; $display("FAIL l3_mac_a[%0d]: got %h expected %h", k, ma1, ea[k]); end
            checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL l3_busy[%0d]: got %b expected 1", k, busy1); end
            step();
        end
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL l3_capt_valid: got %b expected 0", ov1); end
        step();
        checks++; if (ov1 !== 1'b1) begin errors++; $display("FAIL l3_valid_at_8: got %b expected 1", ov1); end
        checks++; if (od1 !== 16'h4120) begin errors++; $display("FAIL l3_data: got %h expected 4120", od1); end
        or1 = 1'b1;
        step();
        or1 = 1'b0;
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL l3_valid_drop: got %b expected 0", ov1); end
        $display("test_mac_lat3 done: out_data=%h", od1);
    endtask

    task automatic test_reset_midop();
        int   cyc;
        logic rdy;
        logic seen;
        av0 = v1a; bv0 = v1b; iv0 = 1'b1; or0 = 1'b0;
        step();
        iv0 = 1'b0;
        step(); step();
        checks++; if (ma0 !== 16'h4040) begin errors++; $display("FAIL rst_mid_idx2: got %h expected 4040", ma0); end
        rst1 = 1'b1;
        #1;
        checks++; if ({mc0, ma0, mb0} !== 33'h0) begin errors++; $display("FAIL rst_mid_mac_drive: got %h expected 0", {mc0, ma0, mb0}); end
        step();
        rst1 = 1'b0;
        checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b expected 1", ir0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy0); end
        checks++; if (od0 !== 16'h0000) begin errors++; $display("FAIL rst_mid_data: got %h expected 0000", od0); end
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            seen = seen | ov0;
            step();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_no_valid: got %b expected 0", seen); end
        iv0 = 1'b1;
        step();
        iv0 = 1'b0;
        wait_u0(cyc, rdy);
        checks++; if (cyc != 6) begin errors++; $display("FAIL rst_mid_fresh_latency: got %0d expected 6", cyc); end
        checks++; if (od0 !== 16'h4120) begin errors++; $display("FAIL rst_mid_fresh_data: got %h expected 4120", od0); end
        or0 = 1'b1;
        step();
        or0 = 1'b0;
        $display("test_reset_midop done: out_data=%h", od0);
    endtask

    task automatic test_n1();
        checks++; if (ir2 !== 1'b1) begin errors++; $display("FAIL n1_idle_ready: got %b expected 1", ir2); end
        av2 = 16'h4040; bv2 = 16'hC000; iv2 = 1'b1;
        step();
        iv2 = 1'b0;
        checks++; if (mc2 !== 1'b0) begin errors++; $display("FAIL n1_cntl_load: got %b expected 0", mc2); end
        checks++; if ({ma2, mb2} !== 32'h4040C000) begin errors++; $display("FAIL n1_operands: got %h expected 4040c000", {ma2, mb2}); end
        step();
        checks++; if (mc2 !== 1'b1) begin errors++; $display("FAIL n1_capt_cntl: got %b expected 1", mc2); end
        checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL n1_capt_valid: got %b expected 0", ov2); end
        checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL n1_busy: got %b expected 1", busy2); end
        step();
        checks++; if (ov2 !== 1'b1) begin errors++; $display("FAIL n1_valid: got %b expected 1", ov2); end
        checks++; if (od2 !== 16'hC0C0) begin errors++; $display("FAIL n1_data: got %h expected c0c0", od2); end
        or2 = 1'b1;
        step();
        or2 = 1'b0;
        checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL n1_valid_drop: got %b expected 0", ov2); end
        $display("test_n1 done: out_data=%h", od2);
    endtask

    initial begin
        test_reset();
        test_dot_basic();
        test_back_to_back();
        test_backpressure();
        test_mac_lat3();
        test_reset_midop();
        test_n1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
